memwb_stage: RTL and testbench
==============================

# memwb_stage

Memory-to-writeback boundary of the 5-stage RV32I pipeline. Registers the MEM-stage control and result fields, aligns and sign- or zero-extends data-memory read data for loads, and produces the final register-file write value. It also drives the WB forwarding source and the 64-bit retired-instruction counter. Data memory is synchronous: read data for a load issued in MEM appears on `DM_DO` during the following (WB) cycle.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `CNT_W`, 64: retired-instruction counter width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hazard unit hold; WB registers keep their values.
- `MEM_valid`  in  1  MEM slot holds a real instruction (0 = bubble).
- `MEM_ALU_out`  in  32  ALU result / memory address.
- `MEM_pc`  in  32  PC of the MEM instruction.
- `MEM_write_addr`  in  5  rd index.
- `MEM_funct3`  in  3  load width/sign code.
- `MEM_RDSrc`  in  1  1 = rd gets `pc+4` (JAL/JALR), 0 = ALU result.
- `MEM_MemtoReg`  in  1  1 = rd gets load data.
- `MEM_MemRead`  in  1  instruction is a load.
- `MEM_RegWrite`  in  1  instruction writes rd.
- `DM_DO`  in  32  data-memory read data, valid in WB cycle.
- `WB_rd_data`  out  32  final write-back value, combinational from WB registers and DM/hold data.
- `WB_write_addr`  out  5  registered rd index.
- `WB_RegWrite`  out  1  registered; forced 0 when `WB_valid`=0 or rd=0.
- `WB_valid`  out  1  registered valid.
- `instret`  out  64  retired-instruction count.

## Operation
- On each posedge with `stall`=0, the block registers the following into WB:
  - `WB_valid`, `WB_write_addr`, `WB_RegWrite`, `WB_MemtoReg`, `WB_funct3`.
  - `WB_off` = `MEM_ALU_out[1:0]`.
  - `WB_alu_rd` = `MEM_RDSrc ? MEM_pc+4 : MEM_ALU_out`. The add wraps modulo 2^32.
- When `stall`=1, all WB registers hold.
- Load extraction uses `WB_funct3`, `WB_off` and source data `src`:
  - `src` = `hold_data` when `hold_valid`=1, else `DM_DO`.
  - 000 LB: `src` byte at `WB_off`, sign-extended.
  - 001 LH: `src` half at `WB_off[1]`, sign-extended.
  - 010 LW: full word; offset ignored.
  - 100 LBU: byte at `WB_off`, zero-extended.
  - 101 LHU: half at `WB_off[1]`, zero-extended.
  - Other codes: full word.
  - Misaligned LH/LHU (`off`=1 or 3) uses `off[1]` only. No trap is raised.
- `WB_rd_data` = `WB_MemtoReg ? load_ext : WB_alu_rd`.
- Hold buffer (memory output may change while the pipeline is frozen):
  - Posedge with `stall`=1 and `hold_valid`=0: `hold_data` ← `DM_DO`, `hold_valid` ← 1.
  - Posedge with `stall`=0: `hold_valid` ← 0.
  - Further stalled cycles keep `hold_data` unchanged.
- `instret` increments at posedge when `stall`=0 and `MEM_valid`=1. It wraps from all-ones to 0.

## Timing
- Reset: every register and output clears immediately and asynchronously. This covers `WB_*`, `hold_data`, `hold_valid`, `instret`, and `WB_rd_data` = 0.
- Latency: MEM-stage inputs appear on WB outputs 1 cycle later. Load data is valid combinationally in that same WB cycle.
- A stall that lasts exactly one cycle: the hold buffer is captured and used during that cycle, then released at the next posedge.
- Reset asserted mid-stall discards the hold buffer. After reset release the first cycle is a bubble.
- `stall` and `MEM_valid` together: no advance and no count.
- Bubble (`MEM_valid`=0): `WB_RegWrite` = 0, whatever `MEM_RegWrite` was.

## Structure
- `cpu_pkg` holds the load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`) and `XLEN`.
- One combinational sub-module, `load_extend`, takes (`data`, `funct3`, `off`) and returns the 32-bit extended value. It is reused by any future load/store unit.

## Test plan
- LB, `ALU_out`=0x1003, `DM_DO`=0x80FF_1234 → `WB_rd_data`=0xFFFF_FF80. LBU, same inputs → 0x0000_0080.
- LH, `off`=2, `DM_DO`=0x8001_7FFF → 0xFFFF_8001. LHU → 0x0000_8001. LH, `off`=0 → 0x0000_7FFF.
- JAL, `MEM_pc`=0x0000_0100, `RDSrc`=1, rd=5 → next cycle `WB_rd_data`=0x104, `WB_write_addr`=5, `WB_RegWrite`=1. With rd=0 → `WB_RegWrite`=0.
- LW in WB, `stall` high 3 cycles, `DM_DO` 0xAAAA_AAAA then 0x5555_5555 → `WB_rd_data` stays 0xAAAA_AAAA for all stall cycles. The next cycle advances.
- 10 valid instructions with 3 bubbles and 2 stall cycles interleaved → `instret`=10. Reset asserted mid-stall → all outputs 0 in the same cycle.
- Preload `instret`=0xFFFF_FFFF_FFFF_FFFF via force, then one valid advance → 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core constants: datapath width and load funct3 encodings.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] ext_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword select ignores off[0]; misaligned halves are not trapped here.
  always_comb begin
    w_byte = data[{off, 3'b000} +: 8];
    w_half = off[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    ext_c = data;
    case (funct3)
      F3_LB:   ext_c = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   ext_c = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LW:   ext_c = data;
      F3_LBU:  ext_c = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  ext_c = {{(XLEN-16){1'b0}}, w_half};
      default: ext_c = data;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline boundary: WB registers, load alignment, write-back mux,
// stall hold buffer for synchronous data memory, and retired-instruction counter.
module memwb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = cpu_pkg::XLEN,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             MEM_valid,
  input  logic [XLEN-1:0]  MEM_ALU_out,
  input  logic [XLEN-1:0]  MEM_pc,
  input  logic [4:0]       MEM_write_addr,
  input  logic [2:0]       MEM_funct3,
  input  logic             MEM_RDSrc,
  input  logic             MEM_MemtoReg,
  input  logic             MEM_MemRead,
  input  logic             MEM_RegWrite,
  input  logic [XLEN-1:0]  DM_DO,
  output logic [XLEN-1:0]  WB_rd_data,
  output logic [4:0]       WB_write_addr,
  output logic             WB_RegWrite,
  output logic             WB_valid,
  output logic [CNT_W-1:0] instret
);

  logic             r_valid;
  logic [4:0]       r_write_addr;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [XLEN-1:0]  r_alu_rd;
  logic [XLEN-1:0]  r_hold_data;
  logic             r_hold_valid;
  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0]  w_src;
  logic [XLEN-1:0]  w_load;
  logic             w_unused;

  // Load qualification is carried by MemtoReg; MemRead is informational only.
  assign w_unused = MEM_MemRead;

  // WB pipeline registers; rd=0 and bubbles never write the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_write_addr <= 5'd0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_alu_rd     <= '0;
    end else if (!stall) begin
      r_valid      <= MEM_valid;
      r_write_addr <= MEM_write_addr;
      r_regwrite   <= MEM_valid & MEM_RegWrite & (|MEM_write_addr);
      r_memtoreg   <= MEM_MemtoReg;
      r_funct3     <= MEM_funct3;
      r_off        <= MEM_ALU_out[1:0];
      r_alu_rd     <= MEM_RDSrc ? (MEM_pc + XLEN'(4)) : MEM_ALU_out;
    end
  end

  // Freeze the first memory word seen under stall; memory may move on meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (!stall) begin
      r_hold_valid <= 1'b0;
    end else if (!r_hold_valid) begin
      r_hold_data  <= DM_DO;
      r_hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (!stall && MEM_valid) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign w_src = r_hold_valid ? r_hold_data : DM_DO;

  load_extend u_load_extend (
    .data   (w_src),
    .funct3 (r_funct3),
    .off    (r_off),
    .ext_c  (w_load)
  );

  assign WB_rd_data    = r_memtoreg ? w_load : r_alu_rd;
  assign WB_write_addr = r_write_addr;
  assign WB_RegWrite   = r_regwrite;
  assign WB_valid      = r_valid;
  assign instret       = r_instret;

endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: directed load/JAL/stall/counter cases
// followed by randomized traffic against a spec-level reference model.
module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        MEM_valid;
  logic [31:0] MEM_ALU_out;
  logic [31:0] MEM_pc;
  logic [4:0]  MEM_write_addr;
  logic [2:0]  MEM_funct3;
  logic        MEM_RDSrc;
  logic        MEM_MemtoReg;
  logic        MEM_MemRead;
  logic        MEM_RegWrite;
  logic [31:0] DM_DO;
  logic [31:0] WB_rd_data;
  logic [4:0]  WB_write_addr;
  logic        WB_RegWrite;
  logic        WB_valid;
  logic [63:0] instret;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the WB stage should hold right now.
  logic        m_valid, m_we, m_mtr, m_holdv;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_alu, m_hold;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  memwb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .MEM_valid      (MEM_valid),
    .MEM_ALU_out    (MEM_ALU_out),
    .MEM_pc         (MEM_pc),
    .MEM_write_addr (MEM_write_addr),
    .MEM_funct3     (MEM_funct3),
    .MEM_RDSrc      (MEM_RDSrc),
    .MEM_MemtoReg   (MEM_MemtoReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_RegWrite   (MEM_RegWrite),
    .DM_DO          (DM_DO),
    .WB_rd_data     (WB_rd_data),
    .WB_write_addr  (WB_write_addr),
    .WB_RegWrite    (WB_RegWrite),
    .WB_valid       (WB_valid),
    .instret        (instret)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Arithmetic view of a load: shift the word down, mask, then fix the sign.
  function automatic logic [31:0] ref_load(input logic [31:0] src, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (src >> (8 * int'(off))) & 32'hFF;
    h = (src >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return src;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_mtr = 0; m_holdv = 0;
    m_rd = 0; m_f3 = 0; m_off = 0; m_alu = 0; m_hold = 0; m_cnt = 0;
  endtask

  task automatic set_mem(input logic v, input logic [2:0] f3, input logic mtr, input logic rdsrc,
                         input logic we, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc);
    MEM_valid = v; MEM_funct3 = f3; MEM_MemtoReg = mtr; MEM_MemRead = mtr;
    MEM_RDSrc = rdsrc; MEM_RegWrite = we; MEM_write_addr = rd;
    MEM_ALU_out = alu; MEM_pc = pc;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    logic [31:0] src;
    #1;
    src = m_holdv ? m_hold : DM_DO;
    check_eq("rd_data", 64'(WB_rd_data), 64'(m_mtr ? ref_load(src, m_f3, m_off) : m_alu));
    check_eq("write_addr", 64'(WB_write_addr), 64'(m_rd));
    check_eq("regwrite", 64'(WB_RegWrite), 64'(m_we));
    check_eq("valid", 64'(WB_valid), 64'(m_valid));
    check_eq("instret", instret, m_cnt);
    @(posedge clk);
    if (!stall) begin
      m_holdv = 0;
      m_valid = MEM_valid;
      m_rd    = MEM_write_addr;
      m_we    = MEM_valid && MEM_RegWrite && (MEM_write_addr != 5'd0);
      m_mtr   = MEM_MemtoReg;
      m_f3    = MEM_funct3;
      m_off   = MEM_ALU_out[1:0];
      m_alu   = MEM_RDSrc ? MEM_pc + 32'd4 : MEM_ALU_out;
      if (MEM_valid) m_cnt = m_cnt + 64'd1;
    end else if (!m_holdv) begin
      m_hold  = DM_DO;
      m_holdv = 1;
    end
    @(negedge clk);
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] dm, input logic [31:0] exp);
    set_mem(1, f3, 1, 0, 1, 5'd4, alu, 32'h0);
    tick();
    set_mem(0, 3'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    DM_DO = dm;
    #1 check_eq(tag, 64'(WB_rd_data), 64'(exp));
  endtask

  int pv[15] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
  int ps[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    reset = 1; stall = 0; DM_DO = 32'h1234_5678;
    set_mem(1, 3'd0, 0, 1, 1, 5'd7, 32'hFFFF_FFFF, 32'h40);
    model_reset();
    @(negedge clk);
    check_eq("rst_rd_data", 64'(WB_rd_data), 64'h0);
    check_eq("rst_valid", 64'(WB_valid), 64'h0);
    check_eq("rst_instret", instret, 64'h0);
    reset = 0;

    load_case("lb", 3'd0, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80);
    load_case("lbu", 3'd4, 32'h1003, 32'h80FF_1234, 32'h0000_0080);
    load_case("lh_off2", 3'd1, 32'h1002, 32'h8001_7FFF, 32'hFFFF_8001);
    load_case("lhu_off2", 3'd5, 32'h1002, 32'h8001_7FFF, 32'h0000_8001);
    load_case("lh_off0", 3'd1, 32'h1000, 32'h8001_7FFF, 32'h0000_7FFF);
    load_case("lh_off3", 3'd1, 32'h1003, 32'h8001_7FFF, 32'hFFFF_8001);
    load_case("lw_off1", 3'd2, 32'h1001, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load_case("f3_011", 3'd3, 32'h1002, 32'h1357_9BDF, 32'h1357_9BDF);

    // JAL link value, rd=0 suppression, and pc+4 wrap
    set_mem(1, 3'd0, 0, 1, 1, 5'd5, 32'hDEAD_BEEF, 32'h100);
    tick();
    set_mem(1, 3'd0, 0, 1, 1, 5'd0, 32'h0, 32'hFFFF_FFFC);
    #1 check_eq("jal_rd", 64'(WB_rd_data), 64'h104);
    check_eq("jal_addr", 64'(WB_write_addr), 64'd5);
    check_eq("jal_we", 64'(WB_RegWrite), 64'd1);
    tick();
    set_mem(0, 3'd0, 0, 0, 1, 5'd9, 32'h55, 32'h0);
    #1 check_eq("rd0_we", 64'(WB_RegWrite), 64'd0);
    check_eq("pc_wrap", 64'(WB_rd_data), 64'h0);
    tick();
    #1 check_eq("bubble_we", 64'(WB_RegWrite), 64'd0);
    check_eq("bubble_valid", 64'(WB_valid), 64'd0);

    // LW in WB frozen for three stalled cycles while memory output changes
    set_mem(1, 3'd2, 1, 0, 1, 5'd6, 32'h2000, 32'h0);
    tick();
    set_mem(1, 3'd0, 0, 0, 1, 5'd7, 32'h77, 32'h0);
    stall = 1; DM_DO = 32'hAAAA_AAAA;
    #1 check_eq("stall_c0", 64'(WB_rd_data), 64'hAAAA_AAAA);
    tick();
    DM_DO = 32'h5555_5555;
    for (int i = 1; i < 3; i++) begin
      #1 check_eq("stall_hold", 64'(WB_rd_data), 64'hAAAA_AAAA);
      tick();
    end
    stall = 0;
    #1 check_eq("stall_release", 64'(WB_rd_data), 64'hAAAA_AAAA);
    tick();
    #1 check_eq("advance_addr", 64'(WB_write_addr), 64'd7);
    check_eq("advance_rd", 64'(WB_rd_data), 64'h77);

    // Retired-instruction count across bubbles and stalls
    reset = 1; #1 reset = 0; model_reset();
    for (int i = 0; i < 15; i++) begin
      set_mem(pv[i][0], 3'd0, 0, 0, 1, 5'(i + 1), 32'(i * 3), 32'h0);
      stall = ps[i][0];
      tick();
    end
    stall = 0;
    set_mem(0, 3'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    #1 check_eq("instret_10", instret, 64'd10);

    // Reset in the middle of a stall clears everything immediately
    stall = 1;
    set_mem(1, 3'd2, 1, 0, 1, 5'd3, 32'h0, 32'h0);
    tick();
    #2 reset = 1;
    #1 check_eq("midrst_rd", 64'(WB_rd_data), 64'h0);
    check_eq("midrst_addr", 64'(WB_write_addr), 64'h0);
    check_eq("midrst_we", 64'(WB_RegWrite), 64'h0);
    check_eq("midrst_valid", 64'(WB_valid), 64'h0);
    check_eq("midrst_instret", instret, 64'h0);
    @(negedge clk);
    reset = 0; stall = 0; model_reset();
    set_mem(0, 3'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick();

    // Counter wrap from all-ones
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.r_instret;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    set_mem(1, 3'd0, 0, 0, 1, 5'd2, 32'h9, 32'h0);
    tick();
    #1 check_eq("instret_wrap", instret, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      set_mem($urandom_range(0, 5) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
      DM_DO = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
